external_io_mc: RTL and testbench

EXTERNAL_IO_MC -- requirements
Module: external_io_mc

---
 rtl/external_io_pkg.sv | 18 +
 rtl/external_io_mc_spi_rx_frame.sv | 74 +++++++
 rtl/external_io_mc.sv | 191 +++++++++++++++++++
 tb/tb_external_io_mc.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/external_io_pkg.sv
// external_io_pkg: SPI1 controller state encoding, SPI mode constants and a
// small sizing helper shared by external_io_mc and its sub-module.
package external_io_pkg;

  typedef enum logic [1:0] {
    SPI1_IDLE   = 2'd0,
    SPI1_CONFIG = 2'd1,
    SPI1_RESULT = 2'd2
  } spi1_state_e;

  localparam int SPI_MODE_0 = 0;
  localparam int SPI_MODE_3 = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/external_io_mc_spi_rx_frame.sv
// spi_rx_frame: one SPI receive port. Synchronises sck/sdi/cs_n into clk,
// detects edges, tracks the frame, counts bits (saturating at SAT) and shifts
// sdi in MSB first on sck rising edges.
module spi_rx_frame #(
  parameter int WIDTH    = 8,
  parameter int SAT      = WIDTH + 1,
  parameter bit SCK_IDLE = 1'b0,
  parameter int CNT_W    = $clog2(SAT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sck,
  input  logic             sdi,
  input  logic             cs_n,
  output logic             frame_start,
  output logic             frame_end,
  output logic             sck_rise,
  output logic             sck_fall,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count
);

  logic [1:0] sck_sync, sdi_sync, cs_sync;
  logic       sck_d, cs_d;
  logic       in_frame, seen_rise, active;

  // Two-flop synchronisers plus a delayed copy for edge detection. cs_n
  // resets low so a frame already open at reset release shows no falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync <= {2{SCK_IDLE}};
      sck_d    <= SCK_IDLE;
      sdi_sync <= '0;
      cs_sync  <= '0;
      cs_d     <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[0], sck};
      sck_d    <= sck_sync[1];
      sdi_sync <= {sdi_sync[0], sdi};
      cs_sync  <= {cs_sync[0], cs_n};
      cs_d     <= cs_sync[1];
    end
  end

  assign frame_start = cs_d & ~cs_sync[1];
  assign frame_end   = in_frame & cs_sync[1] & ~cs_d;
  assign active      = in_frame & ~cs_sync[1];
  assign sck_rise    = active & sck_sync[1] & ~sck_d;
  // The leading falling edge of a mode-3 frame precedes any rise and is dropped.
  assign sck_fall    = active & seen_rise & ~sck_sync[1] & sck_d;

  // Frame tracking, saturating bit counter and MSB-first shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_frame  <= 1'b0;
      seen_rise <= 1'b0;
      data      <= '0;
      count     <= '0;
    end else if (frame_start) begin
      in_frame  <= 1'b1;
      seen_rise <= 1'b0;
      data      <= '0;
      count     <= '0;
    end else begin
      if (frame_end) in_frame <= 1'b0;
      if (sck_rise) begin
        seen_rise <= 1'b1;
        data      <= {data[WIDTH-2:0], sdi_sync[1]};
        if (count != CNT_W'(SAT)) count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/external_io_mc.sv
// external_io_mc: SPI0 job loader (holds the core in reset until a valid job
// frame commits) and SPI1 device-config / result-readout port.
// Build option EXTERNAL_IO_DAISY_CHAIN_EN: sdo0 echoes the SPI0 shift register
// so devices can be chained, and any whole multiple of the job width commits.
//
// SPI1 FSM
//   state   | meaning
//   IDLE    | no SPI1 frame open, sdo1 = 0
//   CONFIG  | receiving device_config, sdo1 = 0
//   RESULT  | shifting latched {result, match_flags} out on sdo1
module external_io_mc
  import external_io_pkg::*;
#(
  parameter int JOB_CONFIG_WIDTH    = 8,
  parameter int DEVICE_CONFIG_WIDTH = 8,
  parameter int RESULT_WIDTH        = 32,
  parameter int MATCH_FLAGS_WIDTH   = 8,
  parameter int SPI_MODE            = SPI_MODE_0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           sck0,
  input  logic                           sdi0,
  input  logic                           cs0_n,
  output logic                           sdo0,
  input  logic                           sck1,
  input  logic                           sdi1,
  input  logic                           cs1_n,
  output logic                           sdo1,
  output logic [JOB_CONFIG_WIDTH-1:0]    job_config,
  output logic [DEVICE_CONFIG_WIDTH-1:0] device_config,
  output logic                           core_reset_n,
  input  logic [MATCH_FLAGS_WIDTH-1:0]   shapool_match_flags,
  input  logic [RESULT_WIDTH-1:0]        shapool_result,
  input  logic                           shapool_success,
  output logic                           ready,
  output logic                           frame_error
);

  localparam int WORD_W   = RESULT_WIDTH + MATCH_FLAGS_WIDTH;
  localparam int SPI1_SAT = max_int(DEVICE_CONFIG_WIDTH, WORD_W) + 1;
  localparam int CNT0_W   = $clog2(JOB_CONFIG_WIDTH + 2);
  localparam int CNT1_W   = $clog2(SPI1_SAT + 1);
  localparam bit SCK_IDLE = (SPI_MODE == SPI_MODE_3);

  logic                           spi0_start, spi0_end, spi0_rise, spi0_fall;
  logic [JOB_CONFIG_WIDTH-1:0]    spi0_data;
  logic [CNT0_W-1:0]              spi0_count;
  logic                           spi1_start, spi1_end, spi1_rise, spi1_fall;
  logic [DEVICE_CONFIG_WIDTH-1:0] spi1_data;
  logic [CNT1_W-1:0]              spi1_count;

  logic              spi0_ok, spi0_bad, spi1_bad, job_commit, unused_sink;
  logic              success_d, success_rise, result_done;
  logic [WORD_W-1:0] result_word, tx_shreg, load_word;
  spi1_state_e       state;

  spi_rx_frame #(
    .WIDTH(JOB_CONFIG_WIDTH), .SAT(JOB_CONFIG_WIDTH + 1), .SCK_IDLE(SCK_IDLE), .CNT_W(CNT0_W)
  ) u_spi0 (
    .clk(clk), .reset(reset), .sck(sck0), .sdi(sdi0), .cs_n(cs0_n),
    .frame_start(spi0_start), .frame_end(spi0_end), .sck_rise(spi0_rise),
    .sck_fall(spi0_fall), .data(spi0_data), .count(spi0_count)
  );

  spi_rx_frame #(
    .WIDTH(DEVICE_CONFIG_WIDTH), .SAT(SPI1_SAT), .SCK_IDLE(SCK_IDLE), .CNT_W(CNT1_W)
  ) u_spi1 (
    .clk(clk), .reset(reset), .sck(sck1), .sdi(sdi1), .cs_n(cs1_n),
    .frame_start(spi1_start), .frame_end(spi1_end), .sck_rise(spi1_rise),
    .sck_fall(spi1_fall), .data(spi1_data), .count(spi1_count)
  );

`ifdef EXTERNAL_IO_DAISY_CHAIN_EN
  localparam int PH_W = $clog2(JOB_CONFIG_WIDTH);
  logic [PH_W-1:0] spi0_phase;
  logic            spi0_any;

  // Bit position within the current job word; a frame is valid on a word boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spi0_phase <= '0;
      spi0_any   <= 1'b0;
    end else if (spi0_start) begin
      spi0_phase <= '0;
      spi0_any   <= 1'b0;
    end else if (spi0_rise) begin
      spi0_any   <= 1'b1;
      spi0_phase <= (spi0_phase == PH_W'(JOB_CONFIG_WIDTH - 1)) ? '0 : spi0_phase + 1'b1;
    end
  end

  // Chain output: the bit leaving the shift register, presented on sck fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           sdo0 <= 1'b0;
    else if (spi0_start) sdo0 <= 1'b0;
    else if (spi0_fall)  sdo0 <= spi0_data[JOB_CONFIG_WIDTH-1];
  end

  // An empty frame carries no job, so at least one bit is required.
  assign spi0_ok     = spi0_any && (spi0_phase == '0);
  assign unused_sink = ^{spi0_count, spi1_rise};
`else
  assign spi0_ok     = (spi0_count == CNT0_W'(JOB_CONFIG_WIDTH));
  assign sdo0        = 1'b0;
  assign unused_sink = ^{spi0_rise, spi0_fall, spi1_rise};
`endif

  assign spi0_bad     = spi0_end & ~spi0_ok;
  assign spi1_bad     = (state == SPI1_CONFIG) & spi1_end &
                        (spi1_count != CNT1_W'(DEVICE_CONFIG_WIDTH));
  assign success_rise = shapool_success & ~success_d;
  assign result_done  = (state == SPI1_RESULT) & spi1_end &
                        (spi1_count >= CNT1_W'(WORD_W));
  assign load_word    = ready ? result_word : {shapool_result, shapool_match_flags};
  assign sdo1         = (state == SPI1_RESULT) & tx_shreg[WORD_W-1];

  // Job commit and core hold: low from frame start, high one clk after a commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      job_config   <= '0;
      job_commit   <= 1'b0;
      core_reset_n <= 1'b0;
    end else begin
      job_commit <= 1'b0;
      if (spi0_end && spi0_ok) begin
        job_config <= spi0_data;
        job_commit <= 1'b1;
      end
      if (spi0_start)      core_reset_n <= 1'b0;
      else if (job_commit) core_reset_n <= 1'b1;
    end
  end

  // Sticky length error from either port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     frame_error <= 1'b0;
    else if (spi0_bad || spi1_bad) frame_error <= 1'b1;
  end

  // Result latch: first success edge wins until the word has been read out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      success_d   <= 1'b0;
      ready       <= 1'b0;
      result_word <= '0;
    end else begin
      success_d <= shapool_success;
      if (success_rise && !ready) begin
        result_word <= {shapool_result, shapool_match_flags};
        ready       <= 1'b1;
      end else if (result_done) begin
        ready <= 1'b0;
      end
    end
  end

  // SPI1 FSM; a success edge coinciding with cs1_n fall is loaded straight in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= SPI1_IDLE;
      tx_shreg      <= '0;
      device_config <= '0;
    end else begin
      case (state)
        SPI1_IDLE: begin
          if (spi1_start) begin
            if (ready || success_rise) begin
              state    <= SPI1_RESULT;
              tx_shreg <= load_word;
            end else begin
              state <= SPI1_CONFIG;
            end
          end
        end
        SPI1_CONFIG: begin
          if (spi1_end) begin
            state <= SPI1_IDLE;
            if (spi1_count == CNT1_W'(DEVICE_CONFIG_WIDTH)) device_config <= spi1_data;
          end
        end
        SPI1_RESULT: begin
          if (spi1_fall) tx_shreg <= {tx_shreg[WORD_W-2:0], 1'b0};
          if (spi1_end)  state <= SPI1_IDLE;
        end
        default: state <= SPI1_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_external_io_mc.sv
`timescale 1ns/1ps
module tb_external_io_mc;

  localparam int HALF = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [2:0]  sck_m, sdi_m, cs_m;   // 0: dut0 spi0, 1: dut0 spi1, 2: dut3 spi1
  logic [2:0]  sdo_m;
  logic [31:0] shapool_result;
  logic [7:0]  shapool_match_flags;
  logic        shapool_success;

  logic       sdo_a0, sdo_a1, core_n_a, ready_a, err_a;
  logic [7:0] job_a, dev_a;
  logic       sdo_b0, sdo_b1, core_n_b, ready_b, err_b;
  logic [7:0] job_b, dev_b;

  assign sdo_m = {sdo_b1, sdo_a1, sdo_a0};

  external_io_mc #(.SPI_MODE(0)) dut0 (
    .clk(clk), .reset(reset),
    .sck0(sck_m[0]), .sdi0(sdi_m[0]), .cs0_n(cs_m[0]), .sdo0(sdo_a0),
    .sck1(sck_m[1]), .sdi1(sdi_m[1]), .cs1_n(cs_m[1]), .sdo1(sdo_a1),
    .job_config(job_a), .device_config(dev_a), .core_reset_n(core_n_a),
    .shapool_match_flags(shapool_match_flags), .shapool_result(shapool_result),
    .shapool_success(shapool_success), .ready(ready_a), .frame_error(err_a)
  );

  external_io_mc #(.SPI_MODE(3)) dut3 (
    .clk(clk), .reset(reset),
    .sck0(1'b1), .sdi0(1'b0), .cs0_n(1'b1), .sdo0(sdo_b0),
    .sck1(sck_m[2]), .sdi1(sdi_m[2]), .cs1_n(cs_m[2]), .sdo1(sdo_b1),
    .job_config(job_b), .device_config(dev_b), .core_reset_n(core_n_b),
    .shapool_match_flags(shapool_match_flags), .shapool_result(shapool_result),
    .shapool_success(shapool_success), .ready(ready_b), .frame_error(err_b)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  logic exp_q[$];

  typedef struct {
    int          which;
    int          nbits;
    logic [63:0] wdata;
    logic [7:0]  exp_job;
    logic [7:0]  exp_dev;
    logic        exp_err;
    logic        exp_core_n;
  } vec_t;

  vec_t vt[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One SPI frame; every sdo sample is popped from the scoreboard queue.
  task automatic spi_xfer(input int which, input int nbits, input logic [63:0] wdata,
                          input bit pulse);
    bit   m3 = (which == 2);
    logic exp_bit;
    cs_m[which] = 1'b0;
    if (pulse) shapool_success = 1'b1;
    repeat (HALF) @(negedge clk);
    if (pulse) shapool_success = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      sdi_m[which] = wdata[nbits-1-i];
      if (m3) sck_m[which] = 1'b0;
      repeat (HALF) @(negedge clk);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sdo_scoreboard_underflow: port %0d bit %0d had no expected value", which, i);
      end else begin
        exp_bit = exp_q.pop_front();
        check($sformatf("sdo_port%0d_bit%0d", which, i), sdo_m[which], exp_bit);
      end
      if (which == 0 && i == nbits - 1) check("core_reset_n_in_frame", core_n_a, 0);
      sck_m[which] = 1'b1;
      repeat (HALF) @(negedge clk);
      if (!m3) sck_m[which] = 1'b0;
    end
    cs_m[which] = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic do_read(input int which, input int nbits, input logic [39:0] word,
                         input bit pulse);
    for (int k = 0; k < nbits; k++) exp_q.push_back(word[39-k]);
    spi_xfer(which, nbits, 64'h0, pulse);
  endtask

  task automatic pulse_success(input logic [31:0] r, input logic [7:0] f);
    shapool_result      = r;
    shapool_match_flags = f;
    shapool_success     = 1'b1;
    repeat (2) @(negedge clk);
    shapool_success = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    sck_m = 3'b100;
    sdi_m = 3'b000;
    cs_m  = 3'b111;
    shapool_result      = '0;
    shapool_match_flags = '0;
    shapool_success     = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    check("rst_job_config", job_a, 0);
    check("rst_device_config", dev_a, 0);
    check("rst_core_reset_n", core_n_a, 0);
    check("rst_ready", ready_a, 0);
    check("rst_frame_error", err_a, 0);
    check("rst_sdo0", sdo_a0, 0);
    check("rst_sdo1", sdo_a1, 0);

    vt[0] = '{0, 8, 64'hAA,  8'hAA, 8'h00, 1'b0, 1'b1};
    vt[1] = '{1, 8, 64'hAA,  8'hAA, 8'hAA, 1'b0, 1'b1};
    vt[2] = '{1, 8, 64'h3C,  8'hAA, 8'h3C, 1'b0, 1'b1};
    vt[3] = '{0, 8, 64'h5C,  8'h5C, 8'h3C, 1'b0, 1'b1};
    vt[4] = '{0, 7, 64'h55,  8'h5C, 8'h3C, 1'b1, 1'b0};
    vt[5] = '{1, 9, 64'h1FF, 8'h5C, 8'h3C, 1'b1, 1'b0};
    vt[6] = '{0, 8, 64'h11,  8'h11, 8'h3C, 1'b1, 1'b1};

    for (int v = 0; v < 7; v++) begin
      for (int k = 0; k < vt[v].nbits; k++) exp_q.push_back(1'b0);
      spi_xfer(vt[v].which, vt[v].nbits, vt[v].wdata, 1'b0);
      check($sformatf("vec%0d_job_config", v), job_a, vt[v].exp_job);
      check($sformatf("vec%0d_device_config", v), dev_a, vt[v].exp_dev);
      check($sformatf("vec%0d_frame_error", v), err_a, vt[v].exp_err);
      check($sformatf("vec%0d_core_reset_n", v), core_n_a, vt[v].exp_core_n);
    end

    // Result readout in mode 0, then the same word from the mode-3 instance.
    pulse_success(32'hEEDDCCBB, 8'hAA);
    check("ready_after_success_m0", ready_a, 1);
    check("ready_after_success_m3", ready_b, 1);
    do_read(1, 40, 40'hEEDDCCBBAA, 1'b0);
    check("ready_cleared_m0", ready_a, 0);
    do_read(2, 40, 40'hEEDDCCBBAA, 1'b0);
    check("ready_cleared_m3", ready_b, 0);

    // Aborted read keeps ready; a success edge while ready is ignored.
    pulse_success(32'hEEDDCCBB, 8'hAA);
    do_read(1, 20, 40'hEEDDCCBBAA, 1'b0);
    check("ready_held_after_abort", ready_a, 1);
    pulse_success(32'h01020304, 8'h55);
    do_read(1, 40, 40'hEEDDCCBBAA, 1'b0);
    check("ready_cleared_after_reread", ready_a, 0);
    do_read(2, 40, 40'hEEDDCCBBAA, 1'b0);
    check("ready_cleared_m3_second", ready_b, 0);

    // Success edge coinciding with cs1_n fall: latched word goes out this frame.
    shapool_result      = 32'hCAFEF00D;
    shapool_match_flags = 8'h3C;
    do_read(2, 40, 40'hCAFEF00D3C, 1'b1);
    check("ready_cleared_simul", ready_b, 0);
    check("ready_m0_latched_simul", ready_a, 1);
    check("device_config_kept_by_reads", dev_a, 8'h3C);
    check("m3_job_config", job_b, 0);
    check("m3_device_config", dev_b, 0);
    check("m3_frame_error", err_b, 0);
    check("m3_core_reset_n", core_n_b, 0);
    check("m3_sdo0", sdo_b0, 0);

    // Frame already open when reset releases must be ignored.
    cs_m[0] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("ready_after_mid_reset", ready_a, 0);
    for (int k = 0; k < 8; k++) exp_q.push_back(1'b0);
    spi_xfer(0, 8, 64'hA5, 1'b0);
    check("open_frame_job_config", job_a, 0);
    check("open_frame_frame_error", err_a, 0);
    check("open_frame_core_reset_n", core_n_a, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
